// File: rtl/mvd_can_mv_fetch.sv
// Spatial MV candidate fetch: latches one A (left) and one B (above) candidate address per PU,
// reads the referenced MV entries and presents both candidates with availability and a done pulse.
module mvd_can_mv_fetch #(
    parameter int unsigned MV_WIDTH = 10,
    parameter int unsigned PIC_X_W  = 8,
    parameter int unsigned TOP_AW   = PIC_X_W + 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_i,
    input  logic [PIC_X_W-1:0]    mb_x_i,
    input  logic [7:0]            a_addr_i,
    input  logic [8:0]            b_addr_i,
    output logic                  cur_rd_en_o,
    output logic [5:0]            cur_rd_addr_o,
    input  logic [2*MV_WIDTH:0]   cur_rd_data_i,
    output logic                  left_rd_en_o,
    output logic [2:0]            left_rd_addr_o,
    input  logic [2*MV_WIDTH:0]   left_rd_data_i,
    output logic                  top_rd_en_o,
    output logic [TOP_AW-1:0]     top_rd_addr_o,
    input  logic [2*MV_WIDTH:0]   top_rd_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  a_valid_o,
    output logic [2*MV_WIDTH-1:0] a_mv_o,
    output logic                  b_valid_o,
    output logic [2*MV_WIDTH-1:0] b_mv_o
);

    localparam int unsigned DW = 2 * MV_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StRdA, StRdB, StCap} state_e;

    state_e               state;
    logic [7:0]           a_addr;
    logic [8:0]           b_addr;
    logic [PIC_X_W-1:0]   mb_x;

    logic [1:0]           a_vld;
    logic [2:0]           a_y;
    logic [2:0]           a_x;
    logic [1:0]           b_vld;
    logic [2:0]           b_y;
    logic [3:0]           b_x;
    logic [TOP_AW-1:0]    top_base;
    logic                 a_read;
    logic                 b_read;
    logic [DW-1:0]        a_data;
    logic [DW-1:0]        b_data;

    assign a_vld    = a_addr[7:6];
    assign a_y      = a_addr[5:3];
    assign a_x      = a_addr[2:0];
    assign b_vld    = b_addr[8:7];
    assign b_y      = b_addr[6:4];
    assign b_x      = b_addr[3:0];
    assign top_base = TOP_AW'({mb_x, 3'b000});

    // Only valid codes 01/10 issue a read; 11 is treated like "not available".
    assign a_read = (a_vld == 2'b10) || (a_vld == 2'b01);
    assign b_read = (b_vld == 2'b10) || (b_vld == 2'b01);
    assign a_data = (a_vld == 2'b10) ? cur_rd_data_i : left_rd_data_i;
    assign b_data = (b_vld == 2'b10) ? cur_rd_data_i : top_rd_data_i;

    assign busy_o = (state != StIdle);

    always_comb begin
        cur_rd_en_o    = 1'b0;
        cur_rd_addr_o  = '0;
        left_rd_en_o   = 1'b0;
        left_rd_addr_o = '0;
        top_rd_en_o    = 1'b0;
        top_rd_addr_o  = '0;
        case (state)
            StRdA: begin
                if (a_vld == 2'b10) begin
                    cur_rd_en_o   = 1'b1;
                    cur_rd_addr_o = {a_y, a_x};
                end else if (a_vld == 2'b01) begin
                    left_rd_en_o   = 1'b1;
                    left_rd_addr_o = a_y;
                end
            end
            StRdB: begin
                if (b_vld == 2'b10) begin
                    cur_rd_en_o   = 1'b1;
                    cur_rd_addr_o = {b_y, b_x[2:0]};
                end else if (b_vld == 2'b01) begin
                    // x = 8 intentionally spills into the next LCU's first column.
                    top_rd_en_o   = 1'b1;
                    top_rd_addr_o = top_base + TOP_AW'(b_x);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= StIdle;
            a_addr    <= '0;
            b_addr    <= '0;
            mb_x      <= '0;
            done_o    <= 1'b0;
            a_valid_o <= 1'b0;
            a_mv_o    <= '0;
            b_valid_o <= 1'b0;
            b_mv_o    <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                StIdle: begin
                    if (start_i) begin
                        a_addr    <= a_addr_i;
                        b_addr    <= b_addr_i;
                        mb_x      <= mb_x_i;
                        a_valid_o <= 1'b0;
                        b_valid_o <= 1'b0;
                        state     <= StRdA;
                    end
                end
                StRdA: state <= StRdB;
                StRdB: begin
                    a_valid_o <= a_read & a_data[DW-1];
                    a_mv_o    <= a_read ? a_data[DW-2:0] : '0;
                    state     <= StCap;
                end
                StCap: begin
                    b_valid_o <= b_read & b_data[DW-1];
                    b_mv_o    <= b_read ? b_data[DW-2:0] : '0;
                    done_o    <= 1'b1;
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mvd_can_mv_fetch.sv
// Directed bench for mvd_can_mv_fetch with simple 1-cycle-latency buffer models.
module tb_mvd_can_mv_fetch;

    localparam int unsigned MVW = 10;
    localparam int unsigned PXW = 8;
    localparam int unsigned TAW = PXW + 3;
    localparam int unsigned DW  = 2 * MVW + 1;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           start_i = 1'b0;
    logic [PXW-1:0] mb_x_i = '0;
    logic [7:0]     a_addr_i = '0;
    logic [8:0]     b_addr_i = '0;
    logic           cur_rd_en_o, left_rd_en_o, top_rd_en_o;
    logic [5:0]     cur_rd_addr_o;
    logic [2:0]     left_rd_addr_o;
    logic [TAW-1:0] top_rd_addr_o;
    logic [DW-1:0]  cur_rd_data_i = '1, left_rd_data_i = '1, top_rd_data_i = '1;
    logic           busy_o, done_o, a_valid_o, b_valid_o;
    logic [DW-2:0]  a_mv_o, b_mv_o;

    logic [DW-1:0]  cur_mem  [0:63];
    logic [DW-1:0]  left_mem [0:7];
    logic [DW-1:0]  top_mem  [0:(1<<TAW)-1];

    int errors = 0;
    int checks = 0;

    mvd_can_mv_fetch #(.MV_WIDTH(MVW), .PIC_X_W(PXW), .TOP_AW(TAW)) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .mb_x_i(mb_x_i),
        .a_addr_i(a_addr_i), .b_addr_i(b_addr_i),
        .cur_rd_en_o(cur_rd_en_o), .cur_rd_addr_o(cur_rd_addr_o), .cur_rd_data_i(cur_rd_data_i),
        .left_rd_en_o(left_rd_en_o), .left_rd_addr_o(left_rd_addr_o),
        .left_rd_data_i(left_rd_data_i),
        .top_rd_en_o(top_rd_en_o), .top_rd_addr_o(top_rd_addr_o), .top_rd_data_i(top_rd_data_i),
        .busy_o(busy_o), .done_o(done_o),
        .a_valid_o(a_valid_o), .a_mv_o(a_mv_o), .b_valid_o(b_valid_o), .b_mv_o(b_mv_o)
    );

    always #5 clk = ~clk;

    // Buffers return all-ones when not enabled so a spurious capture is visible.
    always @(posedge clk) begin
        cur_rd_data_i  <= cur_rd_en_o  ? cur_mem[cur_rd_addr_o]   : '1;
        left_rd_data_i <= left_rd_en_o ? left_mem[left_rd_addr_o] : '1;
        top_rd_data_i  <= top_rd_en_o  ? top_mem[top_rd_addr_o]   : '1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one cycle; returns positioned in cycle T+1.
    task automatic launch(input logic [7:0] a, input logic [8:0] b, input logic [PXW-1:0] mx);
        a_addr_i = a;
        b_addr_i = b;
        mb_x_i   = mx;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy_o, done_o, cur_rd_en_o, cur_rd_addr_o, left_rd_en_o, left_rd_addr_o,
             top_rd_en_o, top_rd_addr_o, a_valid_o, a_mv_o, b_valid_o, b_mv_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b en=%b%b%b a=%b/%h b=%b/%h, want all 0",
                     busy_o, done_o, cur_rd_en_o, left_rd_en_o, top_rd_en_o,
                     a_valid_o, a_mv_o, b_valid_o, b_mv_o);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_cur_a();
        cur_mem[6'h1D] = {1'b1, 10'h3FD, 10'h007};
        launch(8'b10_011_101, 9'b00_000_0000, 8'd0);
        checks++;
        if ({cur_rd_en_o, left_rd_en_o, top_rd_en_o} !== 3'b100 || cur_rd_addr_o !== 6'h1D
            || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL cur_a_rd: en=%b%b%b addr=%h busy=%b, want en=100 addr=1d busy=1",
                     cur_rd_en_o, left_rd_en_o, top_rd_en_o, cur_rd_addr_o, busy_o);
        end
        tick();
        checks++;
        if ({cur_rd_en_o, left_rd_en_o, top_rd_en_o} !== 3'b000
            || {cur_rd_addr_o, left_rd_addr_o, top_rd_addr_o} !== '0) begin
            errors++;
            $display("FAIL cur_a_no_b_rd: en=%b%b%b, want 000 with zero addresses",
                     cur_rd_en_o, left_rd_en_o, top_rd_en_o);
        end
        tick();
        checks++;
        if (busy_o !== 1'b1 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL cur_a_t3: busy=%b done=%b, want busy=1 done=0", busy_o, done_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || a_valid_o !== 1'b1
            || a_mv_o !== {10'h3FD, 10'h007} || b_valid_o !== 1'b0 || b_mv_o !== '0) begin
            errors++;
            $display("FAIL cur_a_done: done=%b busy=%b a=%b/%h b=%b/%h, want 1 0 1/ff407 0/0",
                     done_o, busy_o, a_valid_o, a_mv_o, b_valid_o, b_mv_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b0 || a_valid_o !== 1'b1 || a_mv_o !== {10'h3FD, 10'h007}) begin
            errors++;
            $display("FAIL cur_a_hold: done=%b a=%b/%h, want done=0 a=1/ff407",
                     done_o, a_valid_o, a_mv_o);
        end
    endtask

    task automatic test_left_top();
        left_mem[6] = {1'b1, 10'h010, 10'h3F0};
        top_mem[48] = {1'b1, 10'h005, 10'h3FF};
        launch(8'b01_110_000, 9'b01_111_1000, 8'd5);
        checks++;
        if ({cur_rd_en_o, left_rd_en_o, top_rd_en_o} !== 3'b010 || left_rd_addr_o !== 3'd6) begin
            errors++;
            $display("FAIL left_rd: en=%b%b%b addr=%0d, want en=010 addr=6",
                     cur_rd_en_o, left_rd_en_o, top_rd_en_o, left_rd_addr_o);
        end
        tick();
        checks++;
        if ({cur_rd_en_o, left_rd_en_o, top_rd_en_o} !== 3'b001 || top_rd_addr_o !== 11'd48) begin
            errors++;
            $display("FAIL top_rd: en=%b%b%b addr=%0d, want en=001 addr=48",
                     cur_rd_en_o, left_rd_en_o, top_rd_en_o, top_rd_addr_o);
        end
        tick();
        checks++;
        if ({cur_rd_en_o, left_rd_en_o, top_rd_en_o} !== 3'b000) begin
            errors++;
            $display("FAIL left_top_cap_en: en=%b%b%b, want 000",
                     cur_rd_en_o, left_rd_en_o, top_rd_en_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b1 || a_valid_o !== 1'b1 || a_mv_o !== {10'h010, 10'h3F0}
            || b_valid_o !== 1'b1 || b_mv_o !== {10'h005, 10'h3FF}) begin
            errors++;
            $display("FAIL left_top_done: done=%b a=%b/%h b=%b/%h, want 1 1/043f0 1/017ff",
                     done_o, a_valid_o, a_mv_o, b_valid_o, b_mv_o);
        end
    endtask

    task automatic test_cur_both();
        cur_mem[6'h0A] = {1'b0, 10'h011, 10'h022};
        cur_mem[6'h13] = {1'b0, 10'h033, 10'h044};
        launch(8'b10_001_010, 9'b10_010_0011, 8'd3);
        checks++;
        if ({cur_rd_en_o, left_rd_en_o, top_rd_en_o} !== 3'b100 || cur_rd_addr_o !== 6'h0A) begin
            errors++;
            $display("FAIL cur_both_a: en=%b%b%b addr=%h, want en=100 addr=0a",
                     cur_rd_en_o, left_rd_en_o, top_rd_en_o, cur_rd_addr_o);
        end
        tick();
        checks++;
        if ({cur_rd_en_o, left_rd_en_o, top_rd_en_o} !== 3'b100 || cur_rd_addr_o !== 6'h13) begin
            errors++;
            $display("FAIL cur_both_b: en=%b%b%b addr=%h, want en=100 addr=13",
                     cur_rd_en_o, left_rd_en_o, top_rd_en_o, cur_rd_addr_o);
        end
        tick();
        tick();
        checks++;
        if (done_o !== 1'b1 || a_valid_o !== 1'b0 || b_valid_o !== 1'b0
            || a_mv_o !== {10'h011, 10'h022} || b_mv_o !== {10'h033, 10'h044}) begin
            errors++;
            $display("FAIL cur_both_done: done=%b a=%b/%h b=%b/%h, want 1 0/04422 0/0cc44",
                     done_o, a_valid_o, a_mv_o, b_valid_o, b_mv_o);
        end
    endtask

    task automatic test_no_read();
        launch(8'b00_101_101, 9'b11_101_0101, 8'd7);
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if ({cur_rd_en_o, left_rd_en_o, top_rd_en_o} !== 3'b000 || busy_o !== 1'b1
                || done_o !== 1'b0) begin
                errors++;
                $display("FAIL no_read_t%0d: en=%b%b%b busy=%b done=%b, want 000 1 0", i,
                         cur_rd_en_o, left_rd_en_o, top_rd_en_o, busy_o, done_o);
            end
            tick();
        end
        checks++;
        if (done_o !== 1'b1 || a_valid_o !== 1'b0 || b_valid_o !== 1'b0
            || a_mv_o !== '0 || b_mv_o !== '0) begin
            errors++;
            $display("FAIL no_read_done: done=%b a=%b/%h b=%b/%h, want 1 0/0 0/0",
                     done_o, a_valid_o, a_mv_o, b_valid_o, b_mv_o);
        end
    endtask

    task automatic test_back_to_back();
        launch(8'b10_011_101, 9'b00_000_0000, 8'd0);
        tick();
        // Starts in RD_B and CAP carry a different request that must be dropped.
        a_addr_i = 8'b01_110_000;
        b_addr_i = 9'b01_111_1000;
        mb_x_i   = 8'd5;
        start_i  = 1'b1;
        tick();
        checks++;
        if ({cur_rd_en_o, left_rd_en_o, top_rd_en_o} !== 3'b000 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ignore_t3: en=%b%b%b busy=%b, want 000 1",
                     cur_rd_en_o, left_rd_en_o, top_rd_en_o, busy_o);
        end
        start_i = 1'b0;
        tick();
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || a_valid_o !== 1'b1
            || a_mv_o !== {10'h3FD, 10'h007} || b_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first_done: done=%b busy=%b a=%b/%h b=%b, want 1 0 1/ff407 0",
                     done_o, busy_o, a_valid_o, a_mv_o, b_valid_o);
        end
        launch(8'b00_000_000, 9'b01_111_1000, 8'd5);
        checks++;
        if (busy_o !== 1'b1 || done_o !== 1'b0 || a_valid_o !== 1'b0
            || {cur_rd_en_o, left_rd_en_o, top_rd_en_o} !== 3'b000) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b done=%b a_valid=%b en=%b%b%b, want 1 0 0 000",
                     busy_o, done_o, a_valid_o, cur_rd_en_o, left_rd_en_o, top_rd_en_o);
        end
        tick();
        checks++;
        if (top_rd_en_o !== 1'b1 || top_rd_addr_o !== 11'd48) begin
            errors++;
            $display("FAIL b2b_top_rd: en=%b addr=%0d, want 1 48", top_rd_en_o, top_rd_addr_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_t7: done=%b, want 0", done_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b1 || a_valid_o !== 1'b0 || a_mv_o !== '0 || b_valid_o !== 1'b1
            || b_mv_o !== {10'h005, 10'h3FF}) begin
            errors++;
            $display("FAIL b2b_second_done: done=%b a=%b/%h b=%b/%h, want 1 0/0 1/017ff",
                     done_o, a_valid_o, a_mv_o, b_valid_o, b_mv_o);
        end
    endtask

    task automatic test_reset_mid();
        launch(8'b10_011_101, 9'b01_111_1000, 8'd5);
        tick();
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, cur_rd_en_o, cur_rd_addr_o, left_rd_en_o, left_rd_addr_o,
             top_rd_en_o, top_rd_addr_o, a_valid_o, a_mv_o, b_valid_o, b_mv_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b en=%b%b%b top=%0d a=%b/%h b=%b/%h, want 0",
                     busy_o, done_o, cur_rd_en_o, left_rd_en_o, top_rd_en_o, top_rd_addr_o,
                     a_valid_o, a_mv_o, b_valid_o, b_mv_o);
        end
        tick();
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0 || b_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_release_%0d: done=%b busy=%b b_valid=%b, want 0 0 0",
                         i, done_o, busy_o, b_valid_o);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) cur_mem[i] = '0;
        for (int i = 0; i < 8; i++) left_mem[i] = '0;
        for (int i = 0; i < (1 << TAW); i++) top_mem[i] = '0;
        test_reset();
        test_cur_a();
        test_left_top();
        test_cur_both();
        test_no_read();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
